// File: rtl/lpif_txrx_gearbox.sv
// ---------------------------------------------------------------------------
// lpif_txrx_gearbox
//
// Gearbox between the LPIF adapter and the AIB logic-link FIFOs.
//   TX: collects EFF single-beat LPIF flits into one wide word (slot 0 is the
//       first beat in time) and writes it to the TX FIFO.
//   RX: takes wide words from a first-word-fall-through RX FIFO and replays
//       them as EFF single-beat flits under downstream backpressure.
//   EFF = RATIO in Gen2 mode, max(RATIO/2,1) in Gen1 mode.
//
// Optional feature (macro LPIF_TXRX_GBX_FLUSH_EN): a partially filled TX word
// is forced out after FLUSH_CYCLES idle cycles, unfilled slots zero.
//
// Ports:
//   clk_wr, rst_wr             clock, synchronous active-high reset
//   m_gen2_mode                1 = Gen2 (full ratio), 0 = Gen1 (half ratio)
//   ustrm_beat/vld/rdy         upstream beat handshake
//                              beat = {valid, crc_valid, crc, dvalid, data,
//                                      protid, state}, state in the LSBs
//   txfifo_upstream_data/push  packed TX word and write strobe
//   txfifo_full                TX FIFO full
//   rxfifo_downstream_data     RX FIFO head word (FWFT)
//   rxfifo_empty/pop           RX FIFO status and read strobe
//   dstrm_beat/vld/rdy         downstream beat handshake
// ---------------------------------------------------------------------------
module lpif_txrx_gearbox #(
  parameter int RATIO        = 2,
  parameter int STATE_W      = 4,
  parameter int PROTID_W     = 2,
  parameter int DATA_W       = 64,
  parameter int CRC_W        = 4,
  parameter int FLUSH_CYCLES = 16,
  localparam int BEAT_W      = STATE_W + PROTID_W + DATA_W + CRC_W + 3,
  localparam int WORD_W      = RATIO * BEAT_W
) (
  input  logic              clk_wr,
  input  logic              rst_wr,
  input  logic              m_gen2_mode,
  input  logic [BEAT_W-1:0] ustrm_beat,
  input  logic              ustrm_vld,
  output logic              ustrm_rdy,
  output logic [WORD_W-1:0] txfifo_upstream_data,
  output logic              txfifo_push,
  input  logic              txfifo_full,
  input  logic [WORD_W-1:0] rxfifo_downstream_data,
  input  logic              rxfifo_empty,
  output logic              rxfifo_pop,
  output logic [BEAT_W-1:0] dstrm_beat,
  output logic              dstrm_vld,
  input  logic              dstrm_rdy
);

  localparam int EFF_G1 = (RATIO / 2 > 0) ? RATIO / 2 : 1;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_G2 = CNT_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] LAST_G1 = CNT_W'(EFF_G1 - 1);

  logic              mode_r;
  logic              mode_s;
  logic              idle_s;
  logic [CNT_W-1:0]  last_slot_s;
  logic [CNT_W-1:0]  tx_cnt_r;
  logic              tx_pend_r;
  logic [WORD_W-1:0] tx_word_r;
  logic [WORD_W-1:0] tx_word_nxt_s;
  logic              tx_acc_s;
  logic              tx_last_s;
  logic              tx_flush_s;
  logic [CNT_W-1:0]  rx_cnt_r;
  logic              rx_full_r;
  logic [WORD_W-1:0] rx_word_r;
  logic [BEAT_W-1:0] dstrm_beat_r;
  logic              rx_hs_s;
  logic              rx_last_s;
  logic              pop_s;

  // Mode only moves on a word boundary of both paths; while everything is
  // idle the live input applies so a word starting this cycle already uses it.
  assign idle_s      = (tx_cnt_r == {CNT_W{1'b0}}) & ~tx_pend_r &
                       (rx_cnt_r == {CNT_W{1'b0}}) & ~rx_full_r;
  assign mode_s      = idle_s ? m_gen2_mode : mode_r;
  assign last_slot_s = mode_s ? LAST_G2 : LAST_G1;

  // ---------------- TX path ----------------
  assign ustrm_rdy            = ~rst_wr & (~tx_pend_r | ~txfifo_full);
  assign txfifo_push          = ~rst_wr & tx_pend_r & ~txfifo_full;
  assign txfifo_upstream_data = tx_word_r;
  assign tx_acc_s             = ustrm_vld & ustrm_rdy;
  assign tx_last_s            = tx_acc_s & (tx_cnt_r == last_slot_s);

  // Slot insertion: the first beat clears the word so unused slots read zero
  always_comb begin
    tx_word_nxt_s = tx_word_r;
    if (tx_acc_s) begin
      if (tx_cnt_r == {CNT_W{1'b0}}) begin
        tx_word_nxt_s = WORD_W'(ustrm_beat);
      end else begin
        tx_word_nxt_s = tx_word_r | (WORD_W'(ustrm_beat) << (int'(tx_cnt_r) * BEAT_W));
      end
    end else begin
      tx_word_nxt_s = tx_word_r;
    end
  end

  // Mode latch
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      mode_r <= 1'b0;
    end else begin
      mode_r <= mode_s;
    end
  end

  // TX slot counter, pending flag and word register
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      tx_cnt_r  <= {CNT_W{1'b0}};
      tx_pend_r <= 1'b0;
      tx_word_r <= {WORD_W{1'b0}};
    end else begin
      tx_word_r <= tx_word_nxt_s;
      if (tx_last_s | tx_flush_s) begin
        // covers the back-to-back case where the old word pushes this cycle
        tx_cnt_r  <= {CNT_W{1'b0}};
        tx_pend_r <= 1'b1;
      end else begin
        if (tx_acc_s) begin
          tx_cnt_r <= tx_cnt_r + CNT_W'(1);
        end else begin
          tx_cnt_r <= tx_cnt_r;
        end
        if (txfifo_push) begin
          tx_pend_r <= 1'b0;
        end else begin
          tx_pend_r <= tx_pend_r;
        end
      end
    end
  end

`ifdef LPIF_TXRX_GBX_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);
  logic [IDLE_W-1:0] idle_cnt_r;
  logic              idle_run_s;

  assign idle_run_s = (tx_cnt_r != {CNT_W{1'b0}}) & ~tx_pend_r & ~ustrm_vld;
  assign tx_flush_s = idle_run_s & (idle_cnt_r == IDLE_W'(FLUSH_CYCLES - 1));

  // Idle timer for a partially filled TX word
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end else if (idle_run_s & ~tx_flush_s) begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end else begin
      idle_cnt_r <= {IDLE_W{1'b0}};
    end
  end
`else
  // Partial words never time out; the comparison is constant false and only
  // keeps FLUSH_CYCLES referenced in this build.
  assign tx_flush_s = (FLUSH_CYCLES < 0);
`endif

  // ---------------- RX path ----------------
  assign rx_hs_s    = rx_full_r & dstrm_rdy;
  assign rx_last_s  = rx_hs_s & (rx_cnt_r == last_slot_s);
  // Refill either into an empty buffer or in the cycle its last beat leaves
  assign pop_s      = ~rst_wr & ~rxfifo_empty & (~rx_full_r | rx_last_s);
  assign rxfifo_pop = pop_s;
  assign dstrm_vld  = ~rst_wr & rx_full_r;
  assign dstrm_beat = dstrm_beat_r;

  // RX buffer: remaining slots shift down so the next beat is always at the bottom
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      rx_full_r    <= 1'b0;
      rx_cnt_r     <= {CNT_W{1'b0}};
      rx_word_r    <= {WORD_W{1'b0}};
      dstrm_beat_r <= {BEAT_W{1'b0}};
    end else if (pop_s) begin
      rx_full_r    <= 1'b1;
      rx_cnt_r     <= {CNT_W{1'b0}};
      rx_word_r    <= rxfifo_downstream_data >> BEAT_W;
      dstrm_beat_r <= rxfifo_downstream_data[BEAT_W-1:0];
    end else if (rx_last_s) begin
      rx_full_r    <= 1'b0;
      rx_cnt_r     <= {CNT_W{1'b0}};
    end else if (rx_hs_s) begin
      rx_cnt_r     <= rx_cnt_r + CNT_W'(1);
      rx_word_r    <= rx_word_r >> BEAT_W;
      dstrm_beat_r <= rx_word_r[BEAT_W-1:0];
    end else begin
      rx_full_r    <= rx_full_r;
    end
  end

endmodule
